// File: rtl/ysyx_25060170_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response channels,
// writeback redirect, and the decode-facing instruction handoff.
interface ysyx_25060170_fetch_unit_if;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  // Fetch unit side
  modport master (
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output pc_o,
    output misalign_o
  );

  // Memory / writeback / decode side
  modport slave (
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  pc_o,
    input  misalign_o
  );
endinterface

// File: rtl/ysyx_25060170_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word read at a time,
// holds the fetched word for decode, and squashes fetches on redirect.
//
// state | meaning
// BOOT  | one idle cycle after reset
// REQ   | request valid, address = pc
// WAIT  | request accepted, waiting for response (kill = squash it)
// HOLD  | instruction held for decode
module ysyx_25060170_fetch_unit (
  input  logic                                clk,
  input  logic                                rst,
  ysyx_25060170_fetch_unit_if.master          bus
);

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        kill_q, kill_d;
  logic        misalign_q, misalign_d;

  logic        req_fire;
  logic        redir;

  assign redir    = bus.redirect_valid_i;
  assign req_fire = (state_q == S_REQ) && bus.imem_req_ready_i;

  // Outputs decode straight from registered state; only inst_valid sees redirect
  assign bus.imem_req_valid_o = (state_q == S_REQ);
  assign bus.imem_addr_o      = pc_q;
  assign bus.inst_valid_o     = (state_q == S_HOLD) && !redir;
  assign bus.inst_o           = inst_q;
  assign bus.pc_o             = pc_q;
  assign bus.misalign_o       = misalign_q;

  // Next-state logic; redirect overrides the pc update of every state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    kill_d     = kill_q;
    misalign_d = misalign_q;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          kill_d  = redir;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          if (kill_q || redir) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            inst_d  = bus.imem_rsp_data_i;
            state_d = S_HOLD;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
        end else if (bus.inst_ready_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase

    if (redir) begin
      pc_d = {bus.redirect_pc_i[31:2], 2'b00};
      if (|bus.redirect_pc_i[1:0]) misalign_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_fetch_unit.sv
// Directed bench for the fetch unit with hand-computed expectations.
module tb_ysyx_25060170_fetch_unit;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ysyx_25060170_fetch_unit_if bus ();

  ysyx_25060170_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, land 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'h0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 32'h0;
    bus.inst_ready_i     = 1'b0;
    #3;
    chk("rst_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h0);
    chk("rst_addr", bus.imem_addr_o, 32'h8000_0000);
    chk("rst_inst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_pc", bus.pc_o, 32'h8000_0000);
    chk("rst_misalign", {31'h0, bus.misalign_o}, 32'h0);

    // reset fetch
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_no_req", {31'h0, bus.imem_req_valid_o}, 32'h0);
    tick();
    chk("first_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("first_req_addr", bus.imem_addr_o, 32'h8000_0000);
    bus.imem_req_ready_i = 1'b1;
    tick();
    chk("wait_no_req", {31'h0, bus.imem_req_valid_o}, 32'h0);
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0413;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("first_inst_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    chk("first_inst", bus.inst_o, 32'h0000_0413);
    chk("first_pc", bus.pc_o, 32'h8000_0000);

    // backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_valid", {31'h0, bus.inst_valid_o}, 32'h1);
      chk("bp_inst", bus.inst_o, 32'h0000_0413);
      chk("bp_pc", bus.pc_o, 32'h8000_0000);
      chk("bp_no_req", {31'h0, bus.imem_req_valid_o}, 32'h0);
    end
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    chk("next_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("next_req_addr", bus.imem_addr_o, 32'h8000_0004);

    // request stall
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
      chk("stall_addr", bus.imem_addr_o, 32'h8000_0004);
    end
    bus.imem_req_ready_i = 1'b1;
    tick();
    chk("stall_accepted", {31'h0, bus.imem_req_valid_o}, 32'h0);

    // redirect in WAIT, stale response squashed
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0100;
    tick();
    bus.redirect_valid_i = 1'b0;
    chk("rw_still_wait", {31'h0, bus.imem_req_valid_o}, 32'h0);
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("rw_squash_valid", {31'h0, bus.inst_valid_o}, 32'h0);
    chk("rw_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("rw_req_addr", bus.imem_addr_o, 32'h8000_0100);
    tick();
    chk("rw_wait_valid", {31'h0, bus.inst_valid_o}, 32'h0);
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0010_0093;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("rw_inst_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    chk("rw_inst", bus.inst_o, 32'h0010_0093);
    chk("rw_pc", bus.pc_o, 32'h8000_0100);

    // redirect in HOLD with decode ready, misaligned target
    bus.inst_ready_i     = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h8000_0042;
    #1;
    chk("rh_inst_valid_gated", {31'h0, bus.inst_valid_o}, 32'h0);
    tick();
    bus.inst_ready_i     = 1'b0;
    bus.redirect_valid_i = 1'b0;
    chk("rh_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("rh_req_addr", bus.imem_addr_o, 32'h8000_0040);
    chk("rh_misalign", {31'h0, bus.misalign_o}, 32'h1);
    tick();
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("rh_pc", bus.pc_o, 32'h8000_0040);
    chk("rh_inst", bus.inst_o, 32'h0000_0013);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    chk("rh_next_addr", bus.imem_addr_o, 32'h8000_0044);
    chk("rh_misalign_sticky", {31'h0, bus.misalign_o}, 32'h1);

    // reset while in WAIT
    tick();
    chk("rm_in_wait", {31'h0, bus.imem_req_valid_o}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rm_addr", bus.imem_addr_o, 32'h8000_0000);
    chk("rm_misalign", {31'h0, bus.misalign_o}, 32'h0);
    chk("rm_inst", bus.inst_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    chk("rm_boot_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("rm_boot_addr", bus.imem_addr_o, 32'h8000_0000);
    chk("rm_ignored_valid", {31'h0, bus.inst_valid_o}, 32'h0);
    tick();
    chk("rm_ignored_req", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("rm_ignored_inst", {31'h0, bus.inst_valid_o}, 32'h0);
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    tick();
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0011;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("rm_inst_valid", {31'h0, bus.inst_valid_o}, 32'h1);
    chk("rm_refetch_inst", bus.inst_o, 32'h0000_0011);
    chk("rm_refetch_pc", bus.pc_o, 32'h8000_0000);

    // PC wraparound at top of address space
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid_i = 1'b0;
    chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_no_misalign", {31'h0, bus.misalign_o}, 32'h0);
    tick();
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h0000_0073;
    tick();
    bus.imem_rsp_valid_i = 1'b0;
    chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    chk("wrap_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
    chk("wrap_next_addr", bus.imem_addr_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
